// File: rtl/cookie_spawner.sv
// ---------------------------------------------------------------------------
// cookie_spawner
//
// Places a cookie on the playfield grid using the LFSR's pseudo-random word.
// After a programmable number of game ticks it draws one candidate per clock
// and throws away any candidate that is off-grid or sitting on the player. If
// every candidate is rejected, it uses a fixed fallback spot. The accepted
// position is held until game logic reports that the cookie has been eaten.
// The LFSR only advances while a spawn is pending.
//
// Ports:
//   clk             in   system clock
//   rst_n           in   asynchronous active-low reset
//   tick            in   one-cycle game-tick pulse
//   rnd_number      in   16-bit random word from the LFSR
//   player_x        in   current player column (X_W bits)
//   player_y        in   current player row (Y_W bits)
//   cookie_eaten    in   one-cycle pulse from game logic
//   rnd_en          out  LFSR advance enable
//   cookie_valid    out  a cookie is present at cookie_x/cookie_y
//   cookie_x        out  cookie column
//   cookie_y        out  cookie row
//   cookie_fallback out  current cookie came from the fallback rule
//   spawn_count     out  number of cookies spawned, wraps 255 -> 0
// ---------------------------------------------------------------------------
module cookie_spawner #(
  parameter int GRID_W      = 10,
  parameter int GRID_H      = 8,
  parameter int X_W         = 4,
  parameter int Y_W         = 4,
  parameter int SPAWN_DELAY = 3,
  parameter int MAX_TRIES   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [15:0]    rnd_number,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic           cookie_eaten,
  output logic           rnd_en,
  output logic           cookie_valid,
  output logic [X_W-1:0] cookie_x,
  output logic [Y_W-1:0] cookie_y,
  output logic           cookie_fallback,
  output logic [7:0]     spawn_count
);

  // Counters only ever hold 0..N-1, so clog2(N) bits are enough (minimum 1).
  localparam int DCW = (SPAWN_DELAY > 1) ? $clog2(SPAWN_DELAY) : 1;
  localparam int TCW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [DCW-1:0] DELAY_LAST = DCW'(SPAWN_DELAY - 1);
  localparam logic [TCW-1:0] TRY_LAST   = TCW'(MAX_TRIES - 1);
  localparam logic [X_W-1:0] X_LAST     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST     = Y_W'(GRID_H - 1);

  // Grid limits as 32-bit values so the off-grid test also works when the
  // grid exactly fills the coordinate range (GRID_W == 2^X_W).
  localparam logic [31:0] GRID_W_U = 32'(GRID_W);
  localparam logic [31:0] GRID_H_U = 32'(GRID_H);

  typedef enum logic [1:0] {
    DELAY = 2'd0,
    DRAW  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t         state, next_state;
  logic [DCW-1:0] delay_cnt, next_delay_cnt;
  logic [TCW-1:0] try_cnt, next_try_cnt;

  logic           next_rnd_en;
  logic           next_cookie_valid;
  logic [X_W-1:0] next_cookie_x;
  logic [Y_W-1:0] next_cookie_y;
  logic           next_cookie_fallback;
  logic [7:0]     next_spawn_count;

  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_reject;
  logic           player_at_origin;

  // The candidate takes x from the low byte and y from the high byte of the
  // LFSR word. It is rejected if it is off-grid or on the player's square.
  assign cand_x = rnd_number[X_W-1:0];
  assign cand_y = rnd_number[8+Y_W-1:8];

  assign cand_reject = (32'(cand_x) >= GRID_W_U) ||
                       (32'(cand_y) >= GRID_H_U) ||
                       ((cand_x == player_x) && (cand_y == player_y));

  // The fallback spot is normally the origin. If the player is standing
  // there, the opposite corner is used so the cookie never lands on them.
  assign player_at_origin = (player_x == '0) && (player_y == '0);

  // State and output registers. Every output comes straight from a flop, and
  // reset drops all of them at once, which also abandons any draw in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= DELAY;
      delay_cnt       <= '0;
      try_cnt         <= '0;
      rnd_en          <= 1'b0;
      cookie_valid    <= 1'b0;
      cookie_x        <= '0;
      cookie_y        <= '0;
      cookie_fallback <= 1'b0;
      spawn_count     <= '0;
    end else begin
      state           <= next_state;
      delay_cnt       <= next_delay_cnt;
      try_cnt         <= next_try_cnt;
      rnd_en          <= next_rnd_en;
      cookie_valid    <= next_cookie_valid;
      cookie_x        <= next_cookie_x;
      cookie_y        <= next_cookie_y;
      cookie_fallback <= next_cookie_fallback;
      spawn_count     <= next_spawn_count;
    end
  end

  // Next-state and next-output logic. Everything holds by default. DELAY
  // counts ticks and keeps the LFSR running. DRAW tests one candidate per
  // clock and either accepts it, retries, or falls back after the last try.
  // VALID holds the cookie until it is eaten. Any tick that arrives in VALID
  // is ignored, so the delay always restarts from zero.
  always_comb begin
    next_state           = state;
    next_delay_cnt       = delay_cnt;
    next_try_cnt         = try_cnt;
    next_rnd_en          = rnd_en;
    next_cookie_valid    = cookie_valid;
    next_cookie_x        = cookie_x;
    next_cookie_y        = cookie_y;
    next_cookie_fallback = cookie_fallback;
    next_spawn_count     = spawn_count;

    case (state)
      DELAY: begin
        next_rnd_en = 1'b1;
        if (tick) begin
          if (delay_cnt == DELAY_LAST) begin
            next_state     = DRAW;
            next_delay_cnt = '0;
            next_try_cnt   = '0;
          end else begin
            next_delay_cnt = delay_cnt + 1'b1;
          end
        end
      end

      DRAW: begin
        if (!cand_reject) begin
          next_cookie_x        = cand_x;
          next_cookie_y        = cand_y;
          next_cookie_valid    = 1'b1;
          next_cookie_fallback = 1'b0;
          next_spawn_count     = spawn_count + 8'd1;
          next_rnd_en          = 1'b0;
          next_state           = VALID;
        end else if (try_cnt != TRY_LAST) begin
          next_try_cnt = try_cnt + 1'b1;
        end else begin
          next_cookie_x        = player_at_origin ? X_LAST : '0;
          next_cookie_y        = player_at_origin ? Y_LAST : '0;
          next_cookie_valid    = 1'b1;
          next_cookie_fallback = 1'b1;
          next_spawn_count     = spawn_count + 8'd1;
          next_rnd_en          = 1'b0;
          next_state           = VALID;
        end
      end

      VALID: begin
        if (cookie_eaten) begin
          next_state           = DELAY;
          next_delay_cnt       = '0;
          next_cookie_valid    = 1'b0;
          next_cookie_fallback = 1'b0;
          next_rnd_en          = 1'b1;
        end
      end

      default: begin
        next_state = DELAY;
      end
    endcase
  end

endmodule

// File: tb/tb_cookie_spawner.sv
// ---------------------------------------------------------------------------
// tb_cookie_spawner
//
// Self-checking bench for cookie_spawner (10x8 grid, delay 3, 4 tries).
// Each spawn pushes its expected cookie (position, fallback flag, count and
// latency) into a scoreboard queue, computed by a small reference model. The
// entry is popped and compared when the DUT raises cookie_valid.
// ---------------------------------------------------------------------------
module tb_cookie_spawner;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic [15:0] rnd_number;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic        cookie_eaten;
  logic        rnd_en;
  logic        cookie_valid;
  logic [3:0]  cookie_x;
  logic [3:0]  cookie_y;
  logic        cookie_fallback;
  logic [7:0]  spawn_count;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       fb;
    logic [7:0] cnt;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rnd_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_count = 8'd0;
  logic [3:0]  last_x = 4'd0;
  logic [3:0]  last_y = 4'd0;

  cookie_spawner #(
    .GRID_W(10), .GRID_H(8), .X_W(4), .Y_W(4),
    .SPAWN_DELAY(3), .MAX_TRIES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tick(tick),
    .rnd_number(rnd_number),
    .player_x(player_x),
    .player_y(player_y),
    .cookie_eaten(cookie_eaten),
    .rnd_en(rnd_en),
    .cookie_valid(cookie_valid),
    .cookie_x(cookie_x),
    .cookie_y(cookie_y),
    .cookie_fallback(cookie_fallback),
    .spawn_count(spawn_count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and reports and counts any failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse tick n times; the DUT must not show a cookie while still counting.
  task automatic tickPulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      checkOutput("valid_during_delay", cookie_valid, 1'b0);
      checkOutput("rnd_en_during_delay", rnd_en, 1'b1);
    end
  endtask

  // Feed queued words one per edge until a cookie appears (bounded), then pop
  // the scoreboard and compare everything.
  task automatic waitCookie(input int bound);
    int   edges;
    exp_t e;
    edges = 0;
    while (edges < bound && !cookie_valid) begin
      if (rnd_q.size() > 0) rnd_number = rnd_q.pop_front();
      step();
      edges++;
    end
    checkOutput("cookie_valid", cookie_valid, 1'b1);
    checkOutput("sb_size", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("cookie_x", cookie_x, e.x);
      checkOutput("cookie_y", cookie_y, e.y);
      checkOutput("cookie_fallback", cookie_fallback, e.fb);
      checkOutput("spawn_count", spawn_count, e.cnt);
      checkOutput("rnd_en_valid", rnd_en, 1'b0);
      checkOutput("latency", edges, e.lat);
      last_x = e.x;
      last_y = e.y;
    end
  endtask

  // One full spawn: model the expected cookie, push it, run n_ticks ticks and
  // then feed the four candidate words.
  task automatic applyStimulus(input logic [3:0] px, input logic [3:0] py,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2, input logic [15:0] w3,
                               input int n_ticks);
    logic [15:0] w[4];
    logic [3:0]  cx, cy;
    logic        found;
    exp_t        e;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    found = 1'b0;
    e.x = 4'd0; e.y = 4'd0; e.fb = 1'b0; e.lat = 0;
    for (int i = 0; i < 4; i++) begin
      if (!found) begin
        cx = w[i][3:0];
        cy = w[i][11:8];
        if (cx < 4'd10 && cy < 4'd8 && !(cx == px && cy == py)) begin
          found = 1'b1;
          e.x = cx; e.y = cy; e.fb = 1'b0; e.lat = i + 1;
        end
      end
    end
    if (!found) begin
      e.fb = 1'b1;
      e.lat = 4;
      if (px == 4'd0 && py == 4'd0) begin
        e.x = 4'd9; e.y = 4'd7;
      end else begin
        e.x = 4'd0; e.y = 4'd0;
      end
    end
    exp_count = exp_count + 8'd1;
    e.cnt = exp_count;
    sb.push_back(e);

    player_x = px;
    player_y = py;
    rnd_number = w0;
    tickPulses(n_ticks);
    rnd_q.delete();
    rnd_q.push_back(w0); rnd_q.push_back(w1);
    rnd_q.push_back(w2); rnd_q.push_back(w3);
    waitCookie(6);
    rnd_q.delete();
  endtask

  // Eat the current cookie, optionally with a coinciding tick.
  task automatic eatCookie(input logic with_tick);
    cookie_eaten = 1'b1;
    tick = with_tick;
    step();
    cookie_eaten = 1'b0;
    tick = 1'b0;
    checkOutput("eat_valid", cookie_valid, 1'b0);
    checkOutput("eat_rnd_en", rnd_en, 1'b1);
    checkOutput("eat_fallback", cookie_fallback, 1'b0);
    checkOutput("eat_hold_x", cookie_x, last_x);
    checkOutput("eat_hold_y", cookie_y, last_y);
  endtask

  // Directed sequence followed by a randomised run to wrap spawn_count.
  initial begin
    rst_n = 1'b0;
    tick = 1'b0;
    rnd_number = 16'h0000;
    player_x = 4'd0;
    player_y = 4'd0;
    cookie_eaten = 1'b0;

    // Reset values, then rnd_en rises on the first edge after release.
    repeat (2) step();
    checkOutput("rst_rnd_en", rnd_en, 1'b0);
    checkOutput("rst_valid", cookie_valid, 1'b0);
    checkOutput("rst_x", cookie_x, 4'd0);
    checkOutput("rst_y", cookie_y, 4'd0);
    checkOutput("rst_fallback", cookie_fallback, 1'b0);
    checkOutput("rst_count", spawn_count, 8'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_rnd_en_before_edge", rnd_en, 1'b0);
    step();
    checkOutput("rel_rnd_en", rnd_en, 1'b1);
    checkOutput("rel_valid", cookie_valid, 1'b0);

    // First accept at minimum latency.
    $display("[TB] basic spawn");
    applyStimulus(4'd0, 4'd0, 16'h0305, 16'h0305, 16'h0305, 16'h0305, 3);

    // Three rejects (off-grid x, off-grid y, on player) then accept.
    $display("[TB] reject sequence");
    eatCookie(1'b0);
    applyStimulus(4'd4, 4'd2, 16'h000C, 16'h0902, 16'h0204, 16'h0107, 3);

    // Fallback corners.
    $display("[TB] fallback");
    eatCookie(1'b0);
    applyStimulus(4'd0, 4'd0, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 3);
    eatCookie(1'b0);
    applyStimulus(4'd3, 4'd3, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 3);

    // VALID ignores tick; eat with tick; eat during DELAY does nothing.
    $display("[TB] eat and tick interaction");
    tick = 1'b1;
    step();
    tick = 1'b0;
    checkOutput("valid_hold", cookie_valid, 1'b1);
    checkOutput("valid_hold_rnd_en", rnd_en, 1'b0);
    checkOutput("valid_hold_x", cookie_x, last_x);
    eatCookie(1'b1);
    player_x = 4'd0;
    player_y = 4'd0;
    rnd_number = 16'h0206;
    tickPulses(2);
    cookie_eaten = 1'b1;
    step();
    cookie_eaten = 1'b0;
    checkOutput("delay_eat_valid", cookie_valid, 1'b0);
    checkOutput("delay_eat_rnd_en", rnd_en, 1'b1);
    applyStimulus(4'd0, 4'd0, 16'h0206, 16'h0206, 16'h0206, 16'h0206, 1);

    // Random spawns until spawn_count wraps to zero.
    $display("[TB] random spawns to wrap spawn_count");
    while (exp_count != 8'd0) begin
      logic [3:0] px, py;
      eatCookie(1'b0);
      px = 4'($urandom_range(0, 9));
      py = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        px = 4'd0;
        py = 4'd0;
      end
      applyStimulus(px, py, 16'($urandom()), 16'($urandom()),
                    16'($urandom()), 16'($urandom()), 3);
    end
    checkOutput("count_wrapped", spawn_count, 8'd0);

    // Reset in the middle of a draw: everything clears at once.
    $display("[TB] reset mid-draw");
    eatCookie(1'b0);
    player_x = 4'd0;
    player_y = 4'd0;
    rnd_number = 16'h0F0F;
    tickPulses(3);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rnd_en", rnd_en, 1'b0);
    checkOutput("mid_rst_valid", cookie_valid, 1'b0);
    checkOutput("mid_rst_x", cookie_x, 4'd0);
    checkOutput("mid_rst_y", cookie_y, 4'd0);
    checkOutput("mid_rst_fallback", cookie_fallback, 1'b0);
    checkOutput("mid_rst_count", spawn_count, 8'd0);
    repeat (5) step();
    checkOutput("mid_rst_no_cookie", cookie_valid, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("mid_rel_rnd_en", rnd_en, 1'b1);
    checkOutput("mid_rel_valid", cookie_valid, 1'b0);
    exp_count = 8'd0;
    last_x = 4'd0;
    last_y = 4'd0;
    applyStimulus(4'd0, 4'd0, 16'h0305, 16'h0305, 16'h0305, 16'h0305, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cookie_spawner.md
Name: cookie_spawner

Overview:
- Consumes the 16-bit pseudo-random word from the LFSR and places a cookie on the playfield grid.
- Sequence: waits a programmable number of game ticks, draws candidate coordinates from rnd_number, and rejects any candidate that is off-grid or on the player.
- Holds the accepted position until game logic reports the cookie eaten.
- Drives the LFSR enable, so the LFSR only advances while a spawn is pending.

Parameters:
- GRID_W, 10, number of columns; legal x is 0..GRID_W-1; must be <= 2^X_W.
- GRID_H, 8, number of rows; legal y is 0..GRID_H-1; must be <= 2^Y_W.
- X_W, 4, width of x coordinate.
- Y_W, 4, width of y coordinate.
- SPAWN_DELAY, 3, tick pulses between eat (or reset) and the start of drawing; must be >= 1.
- MAX_TRIES, 4, candidate draws before fallback; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle game-tick pulse
- rnd_number  in  16  random word from LFSR
- player_x  in  X_W  current player column
- player_y  in  Y_W  current player row
- cookie_eaten  in  1  one-cycle pulse from game logic
- rnd_en  out  1  LFSR advance enable
- cookie_valid  out  1  cookie present at cookie_x/cookie_y
- cookie_x  out  X_W  cookie column
- cookie_y  out  Y_W  cookie row
- cookie_fallback  out  1  current cookie came from the fallback rule
- spawn_count  out  8  number of cookies spawned, wraps 255->0

Behaviour:
- All outputs registered.
- Reset (async, rst_n=0):
  - state=DELAY, delay_cnt=0, try_cnt=0.
  - rnd_en, cookie_valid, cookie_x, cookie_y, cookie_fallback, spawn_count all 0.
  - Reset mid-operation discards any draw in progress.
- rnd_en goes 1 on the first clk edge after reset release. It stays 1 throughout DELAY and DRAW, and is 0 in VALID.
- Candidate per cycle: cx = rnd_number[X_W-1:0], cy = rnd_number[8+Y_W-1:8].
- A candidate is rejected if any of these hold: cx >= GRID_W, cy >= GRID_H, or (cx==player_x && cy==player_y).
- DELAY state:
  - On each tick, delay_cnt increments.
  - On a tick with delay_cnt==SPAWN_DELAY-1: go to DRAW, try_cnt=0, delay_cnt=0.
  - cookie_eaten is ignored in this state.
- DRAW state (one candidate evaluated per clk; the first evaluation is on the edge after entering DRAW):
  - Accept: latch cx/cy, then:
    - cookie_valid=1, cookie_fallback=0, spawn_count+=1;
    - go to VALID and clear rnd_en, all on the same edge.
  - Reject with try_cnt < MAX_TRIES-1: try_cnt+=1 and stay in DRAW.
  - Reject with try_cnt == MAX_TRIES-1: take the fallback position, then:
    - cookie_valid=1, cookie_fallback=1, spawn_count+=1;
    - go to VALID.
  - Fallback position is (0,0), unless the player is at (0,0), in which case it is (GRID_W-1, GRID_H-1).
  - tick and cookie_eaten are ignored in this state.
- VALID state:
  - Outputs hold.
  - tick is ignored, including when it coincides with cookie_eaten.
  - cookie_eaten=1: go to DELAY with delay_cnt=0. On the same edge, cookie_valid=0, cookie_fallback=0 and rnd_en=1. cookie_x/cookie_y keep their last values.
- The player moving onto the cookie does not affect this block; detecting that is game logic's job.
- Latency:
  - Minimum from the final tick to cookie_valid is 2 edges: DRAW entry, then first accept.
  - Maximum is MAX_TRIES+1 edges.

Test Plan:
1. Assert rst_n=0 mid-cycle -> all outputs 0 immediately. Release -> rnd_en=1 after the first edge, cookie_valid=0.
2. GRID_W=10, GRID_H=8, SPAWN_DELAY=3, MAX_TRIES=4, player=(0,0). Apply 3 tick pulses, rnd_number=16'h0305 -> cookie_valid=1, (5,3), fallback=0, spawn_count=1, rnd_en=0, exactly 2 edges after the third tick.
3. Player=(4,2); in DRAW drive rnd_number 16'h000C, 16'h0902, 16'h0204, 16'h0107 on successive cycles -> first three rejected; on the 4th edge cookie=(7,1), fallback=0.
4. Four consecutive off-grid words (16'h0F0F) with player=(0,0) -> cookie=(9,7), fallback=1. Repeat with player=(3,3) -> cookie=(0,0), fallback=1.
5. In VALID, pulse cookie_eaten together with tick -> cookie_valid=0 and rnd_en=1 next edge; 3 further ticks are needed to re-enter DRAW. cookie_eaten pulsed during DELAY -> no effect.
6. Spawn 256 cookies -> spawn_count wraps to 0. Assert rst_n=0 mid-DRAW -> immediate return to reset values, no cookie emitted.
